alsu_arbiter: RTL and testbench

//   Shares one ALSU instance between two requesters (r0, r1) using valid/ready command handshakes.

---
 rtl/alsu_arbiter_if.sv | 39 +++
 rtl/alsu_arbiter.sv | 168 ++++++++++++++++
 tb/tb_alsu_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alsu_arbiter_if.sv
// Requester-side command/response channel for alsu_arbiter (one instance per requester).
// Latency: n/a (signal bundle only).
// Backpressure: valid/ready on the command; response is a one-cycle pulse with no ready.
//
// Signals:
//   valid      requester -> arbiter  command valid
//   ready      arbiter -> requester  command accepted when valid & ready at a rising edge
//   cmd[12:0]  requester -> arbiter  [12:10] opcode, [9:7] A, [6:4] B, [3] cin,
//                                    [2] serial_in, [1] red_op_A, [0] red_op_B
//   rsp_valid  arbiter -> requester  one-cycle result pulse
//   rsp_data   arbiter -> requester  6-bit ALSU result
//   rsp_err    arbiter -> requester  ALSU flagged the operation as invalid
interface alsu_arbiter_if;
  logic        valid;
  logic        ready;
  logic [12:0] cmd;
  logic        rsp_valid;
  logic [5:0]  rsp_data;
  logic        rsp_err;

  // master = requester side, slave = arbiter side
  modport master (
    output valid,
    output cmd,
    input  ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_err
  );

  modport slave (
    input  valid,
    input  cmd,
    output ready,
    output rsp_valid,
    output rsp_data,
    output rsp_err
  );
endinterface

// File: rtl/alsu_arbiter.sv
// Round-robin arbiter sharing one ALSU between two requesters, one operation in flight.
// Latency: accept edge e0 -> ALSU sampled at e0+ALSU_LATENCY+1 -> rsp_valid in the next cycle.
// Backpressure: ready only in IDLE for the granted requester; next accept >= e0+ALSU_LATENCY+3.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-low reset
//   r0, r1                requester channels (alsu_arbiter_if.slave)
//   alsu_a/b/opcode       registered ALSU operands and opcode
//   alsu_cin, alsu_serial_in, alsu_red_op_a, alsu_red_op_b   registered ALSU controls
//   alsu_out, alsu_leds   ALSU result and error leds
//   busy                  high whenever an operation is in progress
module alsu_arbiter #(
  parameter int ALSU_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  alsu_arbiter_if.slave     r0,
  alsu_arbiter_if.slave     r1,
  output logic [2:0]        alsu_a,
  output logic [2:0]        alsu_b,
  output logic [2:0]        alsu_opcode,
  output logic              alsu_cin,
  output logic              alsu_serial_in,
  output logic              alsu_red_op_a,
  output logic              alsu_red_op_b,
  input  logic [5:0]        alsu_out,
  input  logic [15:0]       alsu_leds,
  output logic              busy
);

  localparam logic [3:0] WAIT_INIT = 4'(ALSU_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        last_grant;   // requester served most recently (0 = r0, 1 = r1)
  logic        owner;        // requester owning the in-flight operation
  logic        grant;        // candidate winner this cycle
  logic        any_valid;
  logic        accept;
  logic [12:0] cmd_sel;
  logic [3:0]  wait_cnt;

  logic [1:0]  rsp_valid_q;
  logic [5:0]  rsp_data0_q;
  logic [5:0]  rsp_data1_q;
  logic        rsp_err0_q;
  logic        rsp_err1_q;

  // Grant selection: a lone requester always wins; on a tie the one not
  // served last wins, so alternation only happens under contention.
  always_comb begin
    any_valid = r0.valid | r1.valid;
    grant     = 1'b0;
    if (r0.valid && r1.valid) begin
      grant = ~last_grant;
    end else if (r1.valid) begin
      grant = 1'b1;
    end
  end

  assign cmd_sel = grant ? r1.cmd : r0.cmd;

  // Ready is gated by rst so nothing can be accepted while reset is held.
  assign r0.ready = rst & (state == IDLE) & any_valid & ~grant;
  assign r1.ready = rst & (state == IDLE) & any_valid &  grant;
  assign accept   = (r0.valid & r0.ready) | (r1.valid & r1.ready);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Command latch, latency counter and response capture. The alsu_* registers
  // only load on an accept, so the ALSU inputs stay stable for the whole
  // operation and keep the last command afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alsu_a         <= 3'd0;
      alsu_b         <= 3'd0;
      alsu_opcode    <= 3'd0;
      alsu_cin       <= 1'b0;
      alsu_serial_in <= 1'b0;
      alsu_red_op_a  <= 1'b0;
      alsu_red_op_b  <= 1'b0;
      last_grant     <= 1'b1;
      owner          <= 1'b0;
      wait_cnt       <= 4'd0;
      rsp_valid_q    <= 2'b00;
      rsp_data0_q    <= 6'd0;
      rsp_data1_q    <= 6'd0;
      rsp_err0_q     <= 1'b0;
      rsp_err1_q     <= 1'b0;
    end else begin
      rsp_valid_q <= 2'b00;
      case (state)
        IDLE: begin
          if (accept) begin
            alsu_opcode    <= cmd_sel[12:10];
            alsu_a         <= cmd_sel[9:7];
            alsu_b         <= cmd_sel[6:4];
            alsu_cin       <= cmd_sel[3];
            alsu_serial_in <= cmd_sel[2];
            alsu_red_op_a  <= cmd_sel[1];
            alsu_red_op_b  <= cmd_sel[0];
            owner          <= grant;
            last_grant     <= grant;
          end
        end
        ISSUE: begin
          wait_cnt <= WAIT_INIT;
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            // Only the owner's response registers move; the other side holds.
            rsp_valid_q[owner] <= 1'b1;
            if (owner) begin
              rsp_data1_q <= alsu_out;
              rsp_err1_q  <= |alsu_leds;
            end else begin
              rsp_data0_q <= alsu_out;
              rsp_err0_q  <= |alsu_leds;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign r0.rsp_valid = rsp_valid_q[0];
  assign r0.rsp_data  = rsp_data0_q;
  assign r0.rsp_err   = rsp_err0_q;
  assign r1.rsp_valid = rsp_valid_q[1];
  assign r1.rsp_data  = rsp_data1_q;
  assign r1.rsp_err   = rsp_err1_q;

endmodule

// File: tb/tb_alsu_arbiter.sv
// Testbench for alsu_arbiter: two DUTs (latency 2 and 4) each driving a pipelined ALSU model.
// Latency: checks accept-to-response edge counts against ALSU_LATENCY+1.
// Backpressure: exercises held valids, ties, and reset mid-operation.
module tb_alsu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  alsu_arbiter_if r0 ();
  alsu_arbiter_if r1 ();
  alsu_arbiter_if q0 ();
  alsu_arbiter_if q1 ();

  // DUT A: default latency
  logic [2:0]  a_a, a_b, a_op;
  logic        a_cin, a_ser, a_rda, a_rdb, a_busy;
  logic [5:0]  a_out;
  logic [15:0] a_leds;

  alsu_arbiter #(.ALSU_LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .r0(r0), .r1(r1),
    .alsu_a(a_a), .alsu_b(a_b), .alsu_opcode(a_op), .alsu_cin(a_cin),
    .alsu_serial_in(a_ser), .alsu_red_op_a(a_rda), .alsu_red_op_b(a_rdb),
    .alsu_out(a_out), .alsu_leds(a_leds), .busy(a_busy)
  );

  // DUT B: slowed ALSU
  logic [2:0]  b_a, b_b, b_op;
  logic        b_cin, b_ser, b_rda, b_rdb, b_busy;
  logic [5:0]  b_out;
  logic [15:0] b_leds;

  alsu_arbiter #(.ALSU_LATENCY(4)) dut_b (
    .clk(clk), .rst(rst), .r0(q0), .r1(q1),
    .alsu_a(b_a), .alsu_b(b_b), .alsu_opcode(b_op), .alsu_cin(b_cin),
    .alsu_serial_in(b_ser), .alsu_red_op_a(b_rda), .alsu_red_op_b(b_rdb),
    .alsu_out(b_out), .alsu_leds(b_leds), .busy(b_busy)
  );

  // Behavioural ALSU: {err, out}. Invalid opcodes (6,7) or reductions on
  // non-logic ops light the leds and give out=0.
  function automatic logic [6:0] alsu_f(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic cin,
                                        input logic rda, input logic rdb);
    logic [5:0] r;
    r = 6'd0;
    if (op >= 3'd6 || ((rda || rdb) && op > 3'd1)) return 7'h40;
    case (op)
      3'd0: r = {3'b0, a & b};
      3'd1: r = {3'b0, a ^ b};
      3'd2: r = {3'b0, a} + {3'b0, b} + {5'b0, cin};
      3'd3: r = {3'b0, a} * {3'b0, b};
      default: r = 6'd0;
    endcase
    return {1'b0, r};
  endfunction

  logic [6:0] pa [2];
  logic [6:0] pb [4];

  always @(posedge clk) begin
    if (!rst) begin
      pa[0] <= 7'd0; pa[1] <= 7'd0;
    end else begin
      pa[0] <= alsu_f(a_op, a_a, a_b, a_cin, a_rda, a_rdb);
      pa[1] <= pa[0];
    end
  end
  assign a_out  = pa[1][5:0];
  assign a_leds = pa[1][6] ? 16'hffff : 16'h0000;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) pb[i] <= 7'd0;
    end else begin
      pb[0] <= alsu_f(b_op, b_a, b_b, b_cin, b_rda, b_rdb);
      for (int i = 1; i < 4; i++) pb[i] <= pb[i-1];
    end
  end
  assign b_out  = pb[3][5:0];
  assign b_leds = pb[3][6] ? 16'hffff : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] mk(input logic [2:0] op, input logic [2:0] a,
                                     input logic [2:0] b, input logic cin);
    return {op, a, b, cin, 3'b000};
  endfunction

  task automatic set_req(input int n, input logic v, input logic [12:0] c);
    if (n == 0) begin r0.valid = v; r0.cmd = c; end
    else        begin r1.valid = v; r1.cmd = c; end
  endtask

  function automatic logic rdy(input int n);
    return (n == 0) ? r0.ready : r1.ready;
  endfunction

  function automatic logic rspv(input int n);
    return (n == 0) ? r0.rsp_valid : r1.rsp_valid;
  endfunction

  // Issue one command on DUT A and check fields, latency, result and pulse width.
  task automatic run_op(input int n, input logic [12:0] cmd, input logic [5:0] exp_d,
                        input logic exp_e, input string tag);
    int w;
    int lat;
    logic other;
    @(negedge clk);
    set_req(n, 1'b1, cmd);
    #1;
    w = 0;
    while (!rdy(n) && w < 20) begin
      @(negedge clk); #1; w++;
    end
    chk({tag, "_ready"}, {31'b0, rdy(n)}, 32'd1);
    @(posedge clk);
    #1;
    // Corrupt the command after the accept edge: only the accepted value counts.
    set_req(n, 1'b0, 13'h1fff);
    lat = 0;
    other = 1'b0;
    while (!rspv(n) && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (rspv(1 - n)) other = 1'b1;
      if (lat == 1) begin
        chk({tag, "_alsu_fields"}, {20'b0, a_op, a_a, a_b, a_cin, a_ser, a_rda, a_rdb},
            {19'b0, cmd});
      end
    end
    chk({tag, "_latency"}, lat, 32'd3);
    chk({tag, "_data"}, {26'b0, (n == 0) ? r0.rsp_data : r1.rsp_data}, {26'b0, exp_d});
    chk({tag, "_err"}, {31'b0, (n == 0) ? r0.rsp_err : r1.rsp_err}, {31'b0, exp_e});
    chk({tag, "_other_quiet"}, {31'b0, other}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_pulse_1cyc"}, {31'b0, rspv(n)}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int order [4];
    int acc_cyc [4];
    int n_acc;
    int n_rsp0, n_rsp1;
    logic drop;
    int lat;
    int w;

    r0.valid = 1'b0; r0.cmd = 13'd0;
    r1.valid = 1'b0; r1.cmd = 13'd0;
    q0.valid = 1'b0; q0.cmd = 13'd0;
    q1.valid = 1'b0; q1.cmd = 13'd0;

    // Reset state, with r0 requesting to show ready is held low.
    r0.valid = 1'b1;
    r0.cmd = mk(3'd2, 3'd1, 3'd1, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_ready0", {31'b0, r0.ready}, 32'd0);
    chk("rst_busy", {31'b0, a_busy}, 32'd0);
    chk("rst_alsu", {20'b0, a_op, a_a, a_b, a_cin, a_ser, a_rda, a_rdb}, 32'd0);
    chk("rst_rsp", {16'b0, r0.rsp_valid, r1.rsp_valid, r0.rsp_data, r1.rsp_data, r0.rsp_err, r1.rsp_err},
        32'd0);
    r0.valid = 1'b0;
    rst = 1'b1;

    // 1: ADD 3+2
    run_op(0, mk(3'd2, 3'd3, 3'd2, 1'b0), 6'd5, 1'b0, "t1_add");
    // 2: MUL 7*7 on r1; r0 response registers hold
    run_op(1, mk(3'd3, 3'd7, 3'd7, 1'b0), 6'b110001, 1'b0, "t2_mul");
    chk("t2_r0_hold", {26'b0, r0.rsp_data}, 32'd5);
    // 3: invalid opcode, then a normal op
    run_op(0, mk(3'd6, 3'd1, 3'd2, 1'b0), 6'd0, 1'b1, "t3_inv");
    run_op(0, mk(3'd2, 3'd1, 3'd1, 1'b1), 6'd3, 1'b0, "t3_next");
    chk("t3_r1_hold", {26'b0, r1.rsp_data}, 32'd49);

    // 4: both valid from reset, held for four operations
    do_reset();
    r0.valid = 1'b1; r0.cmd = mk(3'd2, 3'd1, 3'd2, 1'b0);
    r1.valid = 1'b1; r1.cmd = mk(3'd3, 3'd2, 3'd3, 1'b0);
    rst = 1'b1;
    n_acc = 0; n_rsp0 = 0; n_rsp1 = 0; drop = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (drop) begin r0.valid = 1'b0; r1.valid = 1'b0; drop = 1'b0; end
      #1;
      if (r0.rsp_valid) n_rsp0++;
      if (r1.rsp_valid) n_rsp1++;
      if ((r0.ready || r1.ready) && n_acc < 4) begin
        order[n_acc] = r1.ready ? 1 : 0;
        acc_cyc[n_acc] = c;
        n_acc++;
        if (n_acc == 4) drop = 1'b1;
      end
      @(negedge clk);
    end
    chk("t4_n_accepts", n_acc, 32'd4);
    chk("t4_order", {28'b0, order[0][0], order[1][0], order[2][0], order[3][0]}, 32'b0101);
    for (int k = 1; k < 4; k++) chk("t4_gap", acc_cyc[k] - acc_cyc[k-1], 32'd5);
    chk("t4_rsp_counts", {n_rsp0[15:0], n_rsp1[15:0]}, {16'd2, 16'd2});
    chk("t4_rsp_data", {20'b0, r0.rsp_data, r1.rsp_data}, {20'b0, 6'd3, 6'd6});

    // 5: reset during WAIT drops the op; r0 wins the tie afterwards
    @(negedge clk);
    r0.valid = 1'b1; r0.cmd = mk(3'd2, 3'd2, 3'd2, 1'b0);
    #1;
    w = 0;
    while (!r0.ready && w < 20) begin @(negedge clk); #1; w++; end
    chk("t5_ready", {31'b0, r0.ready}, 32'd1);
    @(posedge clk); #1;
    r0.valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_busy_wait", {31'b0, a_busy}, 32'd1);
    rst = 1'b0;
    r0.valid = 1'b1; r1.valid = 1'b1;
    r0.cmd = mk(3'd2, 3'd2, 3'd3, 1'b0);
    r1.cmd = mk(3'd3, 3'd1, 3'd1, 1'b0);
    @(negedge clk);
    chk("t5_busy_rst", {31'b0, a_busy}, 32'd0);
    chk("t5_alsu_rst", {20'b0, a_op, a_a, a_b, a_cin, a_ser, a_rda, a_rdb}, 32'd0);
    chk("t5_ready_rst", {30'b0, r0.ready, r1.ready}, 32'd0);
    w = 0;
    for (int c = 0; c < 3; c++) begin
      if (r0.rsp_valid || r1.rsp_valid) w++;
      @(negedge clk);
    end
    chk("t5_no_rsp", w, 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_tie_grant", {30'b0, r0.ready, r1.ready}, 32'b10);
    r0.valid = 1'b0; r1.valid = 1'b0;
    run_op(0, mk(3'd2, 3'd2, 3'd3, 1'b0), 6'd5, 1'b0, "t5_after");

    // 6: ALSU_LATENCY=4 ADD 5+6+1
    @(negedge clk);
    q0.valid = 1'b1; q0.cmd = mk(3'd2, 3'd5, 3'd6, 1'b1);
    #1;
    w = 0;
    while (!q0.ready && w < 20) begin @(negedge clk); #1; w++; end
    chk("t6_ready", {31'b0, q0.ready}, 32'd1);
    @(posedge clk); #1;
    q0.valid = 1'b0;
    lat = 0;
    while (!q0.rsp_valid && lat < 30) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk("t6_latency", lat, 32'd5);
    chk("t6_data", {25'b0, q0.rsp_err, q0.rsp_data}, {25'b0, 1'b0, 6'd12});
    chk("t6_ctrl", {29'b0, b_ser, b_rda, b_rdb}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
